adc_shift_ctrl: RTL and testbench

Frame sequencer for the three-channel ADC shift datapath, running on the single system clock. It holds writable shadow words for channels 0–2 and snapshots them into the datapath inputs at each frame start. It then generates the divided shift clock for exactly BITS bit periods and spaces frames with an idle gap. Frames run on a single-shot request or back-to-back in continuous mode, and the block reports busy, done and overrun status.

---
 rtl/adc_shift_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_adc_shift_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_shift_ctrl.sv
// Frame sequencer for the three-channel ADC shift datapath: shadow registers, frame snapshot,
// divided shift clock generation and inter-frame gap with single-shot/continuous triggering.
module adc_shift_ctrl #(
   parameter int unsigned DIV  = 10,
   parameter int unsigned BITS = 8,
   parameter int unsigned GAP  = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       continuous,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       shift_clk,
   output logic [7:0] reg_0_in,
   output logic [7:0] reg_1_in,
   output logic [7:0] reg_2_in,
   output logic       load,
   output logic       busy,
   output logic       done,
   output logic       overrun
);

   localparam int unsigned GapClks = GAP * 2 * DIV;
   localparam int unsigned DivW    = $clog2(DIV);
   localparam int unsigned BitW    = $clog2(BITS + 1);
   localparam int unsigned GapW    = $clog2(GapClks);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

   state_e            state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [BitW-1:0]   bit_q, bit_d;
   logic [GapW-1:0]   gap_q, gap_d;
   logic              pend_q, pend_d;
   logic              sclk_q, sclk_d;
   logic [7:0]        sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
   logic [7:0]        reg0_q, reg0_d, reg1_q, reg1_d, reg2_q, reg2_d;
   logic              load_q, load_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ovr_q, ovr_d;
   logic              gap_exit;

   // Shadow next-state doubles as the snapshot source so a LOAD-cycle write lands in the frame.
   always_comb begin
      sh0_d = sh0_q;
      sh1_d = sh1_q;
      sh2_d = sh2_q;
      if (wr_en) begin
         case (wr_addr)
            2'd0:    sh0_d = wr_data;
            2'd1:    sh1_d = wr_data;
            2'd2:    sh2_d = wr_data;
            default: ;
         endcase
      end
   end

   assign gap_exit = (state_q == StGap) && (gap_q == GapW'(GapClks - 1));

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      pend_d  = pend_q;
      sclk_d  = sclk_q;
      reg0_d  = reg0_q;
      reg1_d  = reg1_q;
      reg2_d  = reg2_q;
      done_d  = 1'b0;
      ovr_d   = 1'b0;

      case (state_q)
         StIdle: begin
            div_d  = '0;
            sclk_d = 1'b0;
            if (start || continuous) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            reg0_d  = sh0_d;
            reg1_d  = sh1_d;
            reg2_d  = sh2_d;
            bit_d   = '0;
            div_d   = '0;
            state_d = StShift;
         end
         StShift: begin
            // Registered done must be high during the last SHIFT cycle, so decode one cycle early.
            done_d = sclk_q && (bit_q == BitW'(BITS)) && (div_q == DivW'(DIV - 2));
            if (div_q == DivW'(DIV - 1)) begin
               div_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  bit_d  = bit_q + BitW'(1);
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == BitW'(BITS)) begin
                     gap_d   = '0;
                     state_d = StGap;
                  end
               end
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StGap: begin
            sclk_d = 1'b0;
            if (gap_exit) begin
               gap_d   = '0;
               state_d = (continuous || pend_q || start) ? StLoad : StIdle;
            end else begin
               gap_d = gap_q + GapW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // A start on the gap exit cycle is consumed by the next LOAD unless something else claims it.
      if (gap_exit) begin
         pend_d = start && (pend_q || continuous);
      end else if (start && (state_q != StIdle)) begin
         if (pend_q) begin
            ovr_d = 1'b1;
         end else begin
            pend_d = 1'b1;
         end
      end

      load_d = (state_d == StLoad);
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         div_q   <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         pend_q  <= 1'b0;
         sclk_q  <= 1'b0;
         sh0_q   <= 8'h00;
         sh1_q   <= 8'h00;
         sh2_q   <= 8'h00;
         reg0_q  <= 8'h00;
         reg1_q  <= 8'h00;
         reg2_q  <= 8'h00;
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         pend_q  <= pend_d;
         sclk_q  <= sclk_d;
         sh0_q   <= sh0_d;
         sh1_q   <= sh1_d;
         sh2_q   <= sh2_d;
         reg0_q  <= reg0_d;
         reg1_q  <= reg1_d;
         reg2_q  <= reg2_d;
         load_q  <= load_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   assign shift_clk = sclk_q;
   assign reg_0_in  = reg0_q;
   assign reg_1_in  = reg1_q;
   assign reg_2_in  = reg2_q;
   assign load      = load_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_adc_shift_ctrl.sv
// Self-checking bench for adc_shift_ctrl; expected waveforms come from frame-phase arithmetic.
module tb_adc_shift_ctrl;

   localparam int D      = 10;
   localparam int B      = 8;
   localparam int G      = 2;
   localparam int FRAME  = 2 * D * (B + G);
   localparam int PERIOD = FRAME + 1;
   localparam int DONE_P = 2 * B * D;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       continuous = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = 2'd0;
   logic [7:0] wr_data = 8'h00;
   logic       shift_clk;
   logic [7:0] reg_0_in, reg_1_in, reg_2_in;
   logic       load, busy, done, overrun;

   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] sh [4];

   adc_shift_ctrl #(.DIV(D), .BITS(B), .GAP(G)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .continuous (continuous),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .shift_clk  (shift_clk),
      .reg_0_in   (reg_0_in),
      .reg_1_in   (reg_1_in),
      .reg_2_in   (reg_2_in),
      .load       (load),
      .busy       (busy),
      .done       (done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Model: p is the cycle offset from the LOAD cycle of a frame.
   function automatic logic m_sclk(input int p);
      if (p < D + 1 || p > DONE_P) return 1'b0;
      return (((p - 1) / D) % 2) == 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = d;
      if (a != 2'd3) sh[a] = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) sh[i] = 8'h00;
      repeat (3) tick();
      n_tests++; if (shift_clk !== 1'b0) begin n_fail++; $display("FAIL reset shift_clk got %b exp 0", shift_clk); end
      n_tests++; if (reg_0_in !== 8'h00) begin n_fail++; $display("FAIL reset reg_0_in got %h exp 00", reg_0_in); end
      n_tests++; if (reg_1_in !== 8'h00) begin n_fail++; $display("FAIL reset reg_1_in got %h exp 00", reg_1_in); end
      n_tests++; if (reg_2_in !== 8'h00) begin n_fail++; $display("FAIL reset reg_2_in got %h exp 00", reg_2_in); end
      n_tests++; if (load !== 1'b0) begin n_fail++; $display("FAIL reset load got %b exp 0", load); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b exp 0", busy); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b exp 0", done); end
      n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset overrun got %b exp 0", overrun); end
      reset_n = 1'b1;
      repeat (3) tick();
      n_tests++; if (busy !== 1'b0 || load !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy/load got %b/%b exp 0/0", busy, load); end
   endtask

   task automatic test_basic_frame();
      logic [7:0] e0, e1, e2;
      int rises, last_rise;
      for (int it = 0; it < 3; it++) begin
         if (it == 0) begin
            wr(2'd0, 8'hab); wr(2'd1, 8'hcd); wr(2'd2, 8'hef);
         end else begin
            wr(2'd0, 8'($urandom_range(255, 0)));
            wr(2'd1, 8'($urandom_range(255, 0)));
            wr(2'd2, 8'($urandom_range(255, 0)));
         end
         e0 = sh[0]; e1 = sh[1]; e2 = sh[2];
         start = 1'b1; tick(); start = 1'b0;
         rises = 0; last_rise = -1;
         for (int p = 0; p <= FRAME + 1; p++) begin
            n_tests++; if (load !== (p == 0)) begin n_fail++; $display("FAIL basic load p=%0d got %b exp %b", p, load, p == 0); end
            n_tests++; if (busy !== (p <= FRAME)) begin n_fail++; $display("FAIL basic busy p=%0d got %b exp %b", p, busy, p <= FRAME); end
            n_tests++; if (done !== (p == DONE_P)) begin n_fail++; $display("FAIL basic done p=%0d got %b exp %b", p, done, p == DONE_P); end
            n_tests++; if (shift_clk !== m_sclk(p)) begin n_fail++; $display("FAIL basic shift_clk p=%0d got %b exp %b", p, shift_clk, m_sclk(p)); end
            if (p >= 1) begin
               n_tests++;
               if (reg_0_in !== e0 || reg_1_in !== e1 || reg_2_in !== e2) begin
                  n_fail++;
                  $display("FAIL basic regs p=%0d got %h/%h/%h exp %h/%h/%h", p, reg_0_in, reg_1_in, reg_2_in, e0, e1, e2);
               end
            end
            if (shift_clk === 1'b1 && (p == 0 || m_sclk(p - 1) == 1'b0 || last_rise == p - 1 - 2 * D)) begin
               if (last_rise < 0 || p - last_rise >= 2 * D) begin
                  if (last_rise >= 0) begin
                     n_tests++; if (p - last_rise != 2 * D) begin n_fail++; $display("FAIL basic rise_spacing got %0d exp %0d", p - last_rise, 2 * D); end
                  end
                  rises++; last_rise = p;
               end
            end
            tick();
         end
         n_tests++; if (rises != B) begin n_fail++; $display("FAIL basic rise_count got %0d exp %0d", rises, B); end
      end
   endtask

   task automatic test_write_through();
      logic [7:0] old0, nv;
      wr(2'd0, 8'($urandom_range(255, 0)));
      wr(2'd1, 8'($urandom_range(255, 0)));
      wr(2'd2, 8'($urandom_range(255, 0)));
      start = 1'b1; tick(); start = 1'b0;
      n_tests++; if (load !== 1'b1) begin n_fail++; $display("FAIL wt load got %b exp 1", load); end
      wr(2'd1, 8'h5a);
      n_tests++; if (reg_1_in !== 8'h5a) begin n_fail++; $display("FAIL wt reg_1_in got %h exp 5a", reg_1_in); end
      n_tests++; if (reg_0_in !== sh[0] || reg_2_in !== sh[2]) begin n_fail++; $display("FAIL wt regs02 got %h/%h exp %h/%h", reg_0_in, reg_2_in, sh[0], sh[2]); end
      old0 = sh[0];
      nv = ~old0;
      for (int p = 1; p <= FRAME + 1; p++) begin
         if (p == 50) begin
            wr_en = 1'b1; wr_addr = 2'd0; wr_data = nv; sh[0] = nv;
         end else begin
            wr_en = 1'b0;
         end
         n_tests++; if (reg_0_in !== old0) begin n_fail++; $display("FAIL wt hold p=%0d got %h exp %h", p, reg_0_in, old0); end
         tick();
      end
      wr_en = 1'b0;
      start = 1'b1; tick(); start = 1'b0; tick();
      n_tests++; if (reg_0_in !== nv) begin n_fail++; $display("FAIL wt next_load got %h exp %h", reg_0_in, nv); end
      repeat (FRAME + 1) tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wt drain busy got %b exp 0", busy); end
   endtask

   task automatic test_continuous();
      int loads, last_load, q, f;
      logic eb, ed, el, es;
      loads = 0; last_load = -1;
      continuous = 1'b1; tick();
      for (int p = 0; p <= 3 * PERIOD + 20; p++) begin
         if (p == 2 * PERIOD + 50) continuous = 1'b0;
         q = p % PERIOD; f = p / PERIOD;
         eb = (f <= 2);
         el = eb && q == 0;
         ed = eb && q == DONE_P;
         es = eb && m_sclk(q);
         n_tests++; if (load !== el) begin n_fail++; $display("FAIL cont load p=%0d got %b exp %b", p, load, el); end
         n_tests++; if (busy !== eb) begin n_fail++; $display("FAIL cont busy p=%0d got %b exp %b", p, busy, eb); end
         n_tests++; if (done !== ed) begin n_fail++; $display("FAIL cont done p=%0d got %b exp %b", p, done, ed); end
         n_tests++; if (shift_clk !== es) begin n_fail++; $display("FAIL cont shift_clk p=%0d got %b exp %b", p, shift_clk, es); end
         if (load === 1'b1) begin
            if (last_load >= 0) begin
               n_tests++; if (p - last_load != PERIOD) begin n_fail++; $display("FAIL cont period got %0d exp %0d", p - last_load, PERIOD); end
            end
            loads++; last_load = p;
         end
         tick();
      end
      n_tests++; if (loads != 3) begin n_fail++; $display("FAIL cont load_count got %0d exp 3", loads); end
   endtask

   task automatic test_pending_overrun();
      int loads, q;
      logic eb, es;
      loads = 0;
      start = 1'b1; tick(); start = 1'b0;
      for (int p = 0; p <= 2 * PERIOD + 20; p++) begin
         q = p % PERIOD;
         eb = (p < 2 * PERIOD);
         es = eb && m_sclk(q);
         n_tests++; if (overrun !== (p == 31)) begin n_fail++; $display("FAIL pend overrun p=%0d got %b exp %b", p, overrun, p == 31); end
         n_tests++; if (load !== (p == 0 || p == PERIOD)) begin n_fail++; $display("FAIL pend load p=%0d got %b", p, load); end
         n_tests++; if (busy !== eb) begin n_fail++; $display("FAIL pend busy p=%0d got %b exp %b", p, busy, eb); end
         n_tests++; if (done !== (eb && q == DONE_P)) begin n_fail++; $display("FAIL pend done p=%0d got %b", p, done); end
         n_tests++; if (shift_clk !== es) begin n_fail++; $display("FAIL pend shift_clk p=%0d got %b exp %b", p, shift_clk, es); end
         if (load === 1'b1) loads++;
         start = (p == 5 || p == 30);
         tick();
      end
      start = 1'b0;
      n_tests++; if (loads != 2) begin n_fail++; $display("FAIL pend load_count got %0d exp 2", loads); end
   endtask

   task automatic test_gap_exit_start();
      start = 1'b1; tick(); start = 1'b0;
      for (int p = 0; p < FRAME; p++) tick();
      n_tests++; if (busy !== 1'b1 || load !== 1'b0) begin n_fail++; $display("FAIL gapexit last_gap busy/load got %b/%b exp 1/0", busy, load); end
      start = 1'b1; tick(); start = 1'b0;
      n_tests++; if (load !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL gapexit reload load/busy got %b/%b exp 1/1", load, busy); end
      repeat (FRAME + 1) tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gapexit drain busy got %b exp 0", busy); end
   endtask

   task automatic test_reset_abort();
      logic seen_done;
      start = 1'b1; tick(); start = 1'b0;
      for (int p = 0; p < 1 + 7 * D; p++) tick();
      n_tests++; if (shift_clk !== 1'b1) begin n_fail++; $display("FAIL abort fourth_rise got %b exp 1", shift_clk); end
      #2 reset_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) sh[i] = 8'h00;
      n_tests++; if (shift_clk !== 1'b0) begin n_fail++; $display("FAIL abort shift_clk got %b exp 0", shift_clk); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy got %b exp 0", busy); end
      n_tests++; if ({reg_0_in, reg_1_in, reg_2_in} !== 24'h0) begin n_fail++; $display("FAIL abort regs got %h/%h/%h exp 0", reg_0_in, reg_1_in, reg_2_in); end
      seen_done = 1'b0;
      repeat (3) begin tick(); if (done !== 1'b0) seen_done = 1'b1; end
      reset_n = 1'b1;
      repeat (DONE_P) begin tick(); if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1; end
      n_tests++; if (seen_done) begin n_fail++; $display("FAIL abort no_done got activity exp none"); end
      start = 1'b1; tick(); start = 1'b0;
      for (int p = 0; p <= FRAME + 1; p++) begin
         if (p >= 1) begin
            n_tests++; if ({reg_0_in, reg_1_in, reg_2_in} !== 24'h0) begin n_fail++; $display("FAIL abort rerun regs p=%0d got %h/%h/%h exp 0", p, reg_0_in, reg_1_in, reg_2_in); end
         end
         n_tests++; if (done !== (p == DONE_P)) begin n_fail++; $display("FAIL abort rerun done p=%0d got %b", p, done); end
         n_tests++; if (shift_clk !== m_sclk(p)) begin n_fail++; $display("FAIL abort rerun shift_clk p=%0d got %b exp %b", p, shift_clk, m_sclk(p)); end
         tick();
      end
   endtask

   task automatic test_addr3();
      for (int it = 0; it < 2; it++) begin
         wr(2'd0, 8'($urandom_range(254, 0)));
         wr(2'd1, 8'($urandom_range(254, 0)));
         wr(2'd2, 8'($urandom_range(254, 0)));
         wr(2'd3, 8'hff);
         start = 1'b1; tick(); start = 1'b0; tick();
         n_tests++;
         if (reg_0_in !== sh[0] || reg_1_in !== sh[1] || reg_2_in !== sh[2]) begin
            n_fail++;
            $display("FAIL addr3 regs got %h/%h/%h exp %h/%h/%h", reg_0_in, reg_1_in, reg_2_in, sh[0], sh[1], sh[2]);
         end
         repeat (FRAME + 1) tick();
         n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL addr3 drain busy got %b exp 0", busy); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_write_through();
      test_continuous();
      test_pending_overrun();
      test_gap_exit_start();
      test_reset_abort();
      test_addr3();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
